player_pos_tx: RTL and testbench
================================

PLAYER_POS_TX -- requirements
Module: player_pos_tx

Interface
REQ-001 Parameter XMAX, default 1023, meaning the largest x coordinate driven on the link; larger inputs are clamped to it.
REQ-002 Parameter YMAX, default 767, meaning the largest y coordinate driven on the link; larger inputs are clamped to it.
REQ-003 Parameter HOLD_CYCLES, default 4, legal range 1..255, meaning the minimum number of clk cycles each driven word stays stable.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 xpos_in  input  12  local player x position, unsigned.
REQ-007 ypos_in  input  12  local player y position, unsigned.
REQ-008 pos_valid  input  1  one-cycle strobe; xpos_in and ypos_in are valid in the same cycle.
REQ-009 JA  output  8  board link pins, y[11:4].
REQ-010 JB  output  8  board link pins, x[7:0].
REQ-011 JC  output  8  board link pins; JC[3:0] = x[11:8], JC[7:4] = y[3:0].
REQ-012 busy  output  1  high while the current word is inside its hold window.

Function
REQ-013 The block SHALL clamp each coordinate independently with an unsigned compare: x_c = min(xpos_in, XMAX), y_c = min(ypos_in, YMAX).
REQ-014 Packing SHALL be exactly: JB = x_c[7:0], JC = {y_c[3:0], x_c[11:8]}, JA = y_c[11:4]; no other encoding is permitted.
REQ-015 JA, JB and JC SHALL be driven directly from flops and SHALL change only on a load event, with all 24 bits updating on the same edge.
REQ-016 The state machine SHALL have two states, IDLE and HOLD, plus an internal counter cnt (8 bit), a pending flag pend, and 24-bit pending position registers.
REQ-017 IDLE with pos_valid=1 SHALL trigger a load on that cycle: outputs take the new packed word on the next edge, state moves to HOLD, and cnt is set to HOLD_CYCLES-1. Latency from strobe to pins is 1 cycle.
REQ-018 IDLE with pos_valid=0: outputs SHALL keep their last value and state SHALL stay IDLE.
REQ-019 HOLD with cnt!=0: cnt SHALL decrement; a pos_valid SHALL overwrite the pending registers and set pend (latest sample wins, earlier ones are dropped); outputs SHALL stay frozen.
REQ-020 HOLD with cnt==0 and pos_valid=1: the block SHALL load the incoming sample (not the pending one), clear pend, reload cnt to HOLD_CYCLES-1, and stay in HOLD.
REQ-021 HOLD with cnt==0, pos_valid=0 and pend=1: the block SHALL load the pending sample, clear pend, reload cnt, and stay in HOLD.
REQ-022 HOLD with cnt==0, pos_valid=0 and pend=0: the block SHALL move to IDLE with outputs unchanged.
REQ-023 Every driven word SHALL therefore stay stable for at least HOLD_CYCLES cycles; with HOLD_CYCLES=1 the block accepts one update per cycle.
REQ-024 busy SHALL equal (state==HOLD), registered, with no combinational path from pos_valid.

Reset
REQ-025 While rst=0 at a clk edge: JA=JB=JC=0x00, busy=0, state=IDLE, cnt=0, pend=0, pending registers=0.
REQ-026 Reset asserted mid-HOLD SHALL discard any pending sample; after release, nothing is driven until a new pos_valid.
REQ-027 A pos_valid in the same cycle as rst=0 SHALL be ignored.

Verification
REQ-028 Hold rst=0 for 2 cycles, then drive pos_valid with xpos_in=0x123 in that cycle -> JA=JB=JC=0x00 and busy=0 after release; the strobe is ignored.
REQ-029 IDLE, single strobe x=0x2A5, y=0x1C3 -> one cycle later JB=0xA5, JC=0x32, JA=0x1C; busy=1 for exactly 4 cycles, then 0; pins stay unchanged afterwards.
REQ-030 Strobe x=0xFFF, y=0x400 -> JB=0xFF, JC=0xF3, JA=0x2F (clamped to 1023 and 767).
REQ-031 Load (1,1), then strobes (2,2) and (3,3) during the hold window -> pins show (1,1) for 4 cycles, then (3,3) for 4 cycles; (2,2) never appears.
REQ-032 Pending sample (5,5) set, then strobe (6,6) in the cnt==0 cycle -> (6,6) loads on the next edge, (5,5) is never driven, and busy stays 1.
REQ-033 Pending sample set, rst=0 for one cycle mid-HOLD -> pins return to 0x00 and remain there; busy=0.

Source files
------------

// File: rtl/player_pos_tx.sv
// player_pos_tx: clamps player x/y, packs them onto the JA/JB/JC link pins and holds each word a minimum time
module player_pos_tx #(
    parameter int XMAX = 1023,
    parameter int YMAX = 767,
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        pos_valid,
    output logic [7:0]  JA,
    output logic [7:0]  JB,
    output logic [7:0]  JC,
    output logic        busy
);
    typedef enum logic {IDLE, HOLD} state_t;
    localparam logic [7:0]  RELOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [11:0] XLIM = 12'(XMAX);
    localparam logic [11:0] YLIM = 12'(YMAX);
    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        pend, pend_n;
    logic [23:0] pend_pos, pend_pos_n, pos, pos_n;
    logic [11:0] x_c, y_c;
    assign x_c = (xpos_in > XLIM) ? XLIM : xpos_in;
    assign y_c = (ypos_in > YLIM) ? YLIM : ypos_in;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        pend_n = pend;
        pend_pos_n = pend_pos;
        pos_n = pos;
        if (state == IDLE) begin
            if (pos_valid) begin
                pos_n = {y_c, x_c};
                state_n = HOLD;
                cnt_n = RELOAD;
            end
        end else if (cnt != 8'd0) begin
            cnt_n = cnt - 8'd1;
            if (pos_valid) begin
                pend_pos_n = {y_c, x_c};
                pend_n = 1'b1;
            end
        end else if (pos_valid || pend) begin
            // a fresh strobe at the end of the window beats the older pending sample
            pos_n = pos_valid ? {y_c, x_c} : pend_pos;
            pend_n = 1'b0;
            cnt_n = RELOAD;
        end else begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= 8'd0;
            pend <= 1'b0;
            pend_pos <= 24'd0;
            pos <= 24'd0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            pend <= pend_n;
            pend_pos <= pend_pos_n;
            pos <= pos_n;
        end
    end
    // pos is {y, x}, so the pin packing falls straight out of its byte lanes
    assign JB = pos[7:0];
    assign JC = pos[15:8];
    assign JA = pos[23:16];
    assign busy = (state == HOLD);
endmodule

// File: tb/tb_player_pos_tx.sv
// tb_player_pos_tx: directed table and sequence checks for player_pos_tx
module tb_player_pos_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] xpos_in = 12'd0;
    logic [11:0] ypos_in = 12'd0;
    logic        pos_valid = 1'b0;
    logic [7:0]  JA, JB, JC;
    logic        busy;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] w;
    } vec_t;
    vec_t tbl[8];

    player_pos_tx dut (
        .clk(clk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in),
        .pos_valid(pos_valid), .JA(JA), .JB(JB), .JC(JC), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [11:0] x, input logic [11:0] y, input logic v);
        xpos_in = x;
        ypos_in = y;
        pos_valid = v;
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string name, input logic [23:0] w, input logic b);
        chk({name, " pins"}, {JA, JC, JB}, w);
        chk({name, " busy"}, {23'd0, busy}, {23'd0, b});
    endtask

    initial begin
        tbl[0] = '{12'h2A5, 12'h1C3, 24'h1C32A5};
        tbl[1] = '{12'hFFF, 12'h400, 24'h2FF3FF};
        tbl[2] = '{12'h3FF, 12'h2FF, 24'h2FF3FF};
        tbl[3] = '{12'h400, 12'h2FF, 24'h2FF3FF};
        tbl[4] = '{12'h000, 12'h000, 24'h000000};
        tbl[5] = '{12'h3FE, 12'h2FE, 24'h2FE3FE};
        tbl[6] = '{12'h100, 12'h012, 24'h012100};
        tbl[7] = '{12'h0AB, 12'h300, 24'h2FF0AB};

        @(negedge clk);
        cyc();
        drive(12'h123, 12'h000, 1'b1);
        cyc();
        drive(12'h000, 12'h000, 1'b0);
        rst = 1'b1;
        chk_state("reset", 24'h000000, 1'b0);
        cyc();
        chk_state("reset strobe ignored", 24'h000000, 1'b0);
        cyc();
        chk_state("reset idle", 24'h000000, 1'b0);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].x, tbl[i].y, 1'b1);
            cyc();
            pos_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                chk_state($sformatf("vec%0d hold%0d", i, k), tbl[i].w, 1'b1);
                cyc();
            end
            chk_state($sformatf("vec%0d release", i), tbl[i].w, 1'b0);
            cyc();
            chk_state($sformatf("vec%0d idle", i), tbl[i].w, 1'b0);
        end

        drive(12'd1, 12'd1, 1'b1);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk_state($sformatf("latest wins c%0d", i), (i < 4) ? 24'h001001 : 24'h003003, 1'b1);
            if (i == 0) drive(12'd2, 12'd2, 1'b1);
            else if (i == 1) drive(12'd3, 12'd3, 1'b1);
            else pos_valid = 1'b0;
            cyc();
        end
        chk_state("latest wins end", 24'h003003, 1'b0);
        cyc();

        drive(12'd4, 12'd4, 1'b1);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk_state($sformatf("fresh beats pend c%0d", i), (i < 4) ? 24'h004004 : 24'h006006, 1'b1);
            if (i == 0) drive(12'd5, 12'd5, 1'b1);
            else if (i == 3) drive(12'd6, 12'd6, 1'b1);
            else pos_valid = 1'b0;
            cyc();
        end
        chk_state("fresh beats pend end", 24'h006006, 1'b0);
        cyc();

        drive(12'd7, 12'd7, 1'b1);
        cyc();
        drive(12'd8, 12'd8, 1'b1);
        chk_state("mid reset pre", 24'h007007, 1'b1);
        cyc();
        pos_valid = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_state($sformatf("mid reset c%0d", i), 24'h000000, 1'b0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
